// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter letting NUM_MASTERS Wishbone masters share
// one Wishbone slave port. A grant is held (bus lock) for as long as the granted
// master keeps m_cyc_i high. Each release costs one idle cycle before the next grant.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a stall watchdog. It signals
// m_err_o to the granted master after TIMEOUT_CYCLES unterminated strobe cycles.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i  per-master request, strobe, write enable
//   m_adr_i, m_dat_i        flattened per-master address / write data
//   m_dat_o                 slave read data, broadcast to every master
//   m_ack_o, m_err_o        per-master termination, routed only to the grantee
//   s_*                     single slave-side Wishbone port
//   gnt_o                   registered one-hot grant
//   busy_o                  high while a master owns the bus
module wb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            gnt_o,
    output logic                              busy_o
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // Elaboration-time parameter range checks
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
        $error("wb_rr_arbiter: NUM_MASTERS must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [0:0]             state, state_nxt;
    logic [IDX_W-1:0]       last, last_nxt;
    logic [NUM_MASTERS-1:0] gnt_nxt;
    logic [IDX_W-1:0]       pick;
    logic                   req_any;

    logic                   gnt_cyc, gnt_stb, gnt_we;
    logic [ADDR_WIDTH-1:0]  gnt_adr;
    logic [DATA_WIDTH-1:0]  gnt_dat;
    logic                   fire;

    assign req_any = |m_cyc_i;

    // Granted master's signals; gnt_o is all-zero in IDLE, so these read 0 there
    always_comb begin
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        gnt_we  = 1'b0;
        gnt_adr = '0;
        gnt_dat = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (gnt_o[k]) begin
                gnt_cyc = m_cyc_i[k];
                gnt_stb = m_stb_i[k];
                gnt_we  = m_we_i[k];
                gnt_adr = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: first requester searching upward from last+1, wrapping
    always_comb begin : rr_pick
        logic [IDX_W:0] cand;
        logic           found;
        pick  = last;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, last} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!found && m_cyc_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            last  <= IDX_W'(NUM_MASTERS - 1);
            gnt_o <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            gnt_o <= gnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        gnt_nxt   = gnt_o;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    state_nxt     = ST_OWNED;
                    last_nxt      = pick;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                end
            end
            ST_OWNED: begin
                // Bus lock: hold until the grantee drops cyc
                if (!gnt_cyc) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic             stall;

    // A stall is a strobed cycle of the grantee with no slave termination
    assign stall = (state == ST_OWNED) & gnt_stb & ~s_ack_i & ~s_err_i;
    assign fire  = stall & (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_cnt_nxt = '0;
        if (stall && !fire && gnt_cyc) begin
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
        end
    end
`else
    assign fire = 1'b0;
`endif

    // Slave port and termination routing are combinational (zero added latency)
    assign s_cyc_o = gnt_cyc;
    assign s_stb_o = gnt_stb & ~fire;
    assign s_we_o  = gnt_we;
    assign s_adr_o = gnt_adr;
    assign s_dat_o = gnt_dat;

    // Terminations reach only the grantee, and only while it strobes
    assign m_ack_o = gnt_o & {NUM_MASTERS{gnt_stb & s_ack_i}};
    assign m_err_o = gnt_o & {NUM_MASTERS{(gnt_stb & s_err_i) | fire}};
    assign m_dat_o = s_dat_i;
    assign busy_o  = (state == ST_OWNED);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack, m_err;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o, s_dat;
    logic              s_ack, s_err;
    logic [NM-1:0]     gnt;
    logic              busy;

    int n_tests;
    int n_fail;

    // Reference model state: owner index (-1 when bus free), last winner, stall count
    int own;
    int last;
    int cnt;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat),
        .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: compare every output against the model at negedge,
    // then advance the model on the rising edge using the same inputs.
    task automatic step();
        logic [NM-1:0] e_gnt, e_ack, e_err;
        logic          e_cyc, e_stb, e_we, fire;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        @(negedge clk);
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; fire = 1'b0;
        if (own >= 0) begin
            e_gnt[own] = 1'b1;
            e_cyc = m_cyc[own];
            e_stb = m_stb[own];
            e_we  = m_we[own];
            e_adr = m_adr[own*AW +: AW];
            e_dat = m_dat[own*DW +: DW];
            if (m_stb[own] && s_ack) e_ack[own] = 1'b1;
            if (m_stb[own] && s_err) e_err[own] = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            if (m_stb[own] && !s_ack && !s_err && cnt == int'(TO) - 1) begin
                fire = 1'b1;
                e_stb = 1'b0;
                e_err[own] = 1'b1;
            end
`endif
        end
        check("gnt",    32'(gnt),     32'(e_gnt));
        check("busy",   32'(busy),    32'(own >= 0));
        check("s_cyc",  32'(s_cyc),   32'(e_cyc));
        check("s_stb",  32'(s_stb),   32'(e_stb));
        check("s_we",   32'(s_we),    32'(e_we));
        check("s_adr",  32'(s_adr),   32'(e_adr));
        check("s_dat",  32'(s_dat_o), 32'(e_dat));
        check("m_ack",  32'(m_ack),   32'(e_ack));
        check("m_err",  32'(m_err),   32'(e_err));
        check("m_dat",  32'(m_dat_o), 32'(s_dat));
        @(posedge clk);
        if (own >= 0 && m_stb[own] && !s_ack && !s_err && !fire) cnt++;
        else cnt = 0;
        if (own < 0) begin
            if (|m_cyc) begin
                for (int i = 1; i <= int'(NM); i++) begin
                    int c;
                    c = (last + i) % int'(NM);
                    if (m_cyc[c]) begin
                        own = c;
                        break;
                    end
                end
                last = own;
            end
        end else if (!m_cyc[own]) begin
            own = -1;
            cnt = 0;
        end
        #1;
    endtask

    task automatic go_idle();
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        own = -1; last = int'(NM) - 1; cnt = 0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        rst_n = 1'b0;

        // Reset values
        #12;
        check("rst_gnt",  32'(gnt),   32'(0));
        check("rst_busy", 32'(busy),  32'(0));
        check("rst_scyc", 32'(s_cyc), 32'(0));
        check("rst_sadr", 32'(s_adr), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All four request continuously, each releases after one transfer
        m_cyc = 4'b1111; m_stb = 4'b1111; s_ack = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            check($sformatf("order_gnt%0d", t), 32'(gnt), 32'(NM'(1) << (t % 4)));
            step();
            m_cyc[t % 4] = 1'b0; m_stb[t % 4] = 1'b0;
            step();
            m_cyc[t % 4] = 1'b1; m_stb[t % 4] = 1'b1;
        end
        go_idle();

        // Single write by master 2
        m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
        m_adr = 8'b00_10_00_00; m_dat = 32'h00A5_0000;
        step();
        s_ack = 1'b1; #1;
        check("wr_gnt", 32'(gnt),     32'(4'b0100));
        check("wr_adr", 32'(s_adr),   32'(2));
        check("wr_dat", 32'(s_dat_o), 32'(8'hA5));
        check("wr_we",  32'(s_we),    32'(1));
        check("wr_ack", 32'(m_ack),   32'(4'b0100));
        step();
        go_idle();

        // Bus lock: master 1 does three reads while master 3 waits
        m_cyc = 4'b0010; m_stb = 4'b0000;
        step();
        m_cyc = 4'b1010; m_stb = 4'b1010; s_ack = 1'b1;
        for (int r = 0; r < 3; r++) begin
            s_dat = DW'($urandom);
            #1;
            check($sformatf("lock_gnt%0d", r), 32'(gnt),   32'(4'b0010));
            check($sformatf("lock_ack%0d", r), 32'(m_ack), 32'(4'b0010));
            step();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
        step();
        step();
        check("lock_next_gnt", 32'(gnt), 32'(4'b1000));
        go_idle();

        // Error routing to master 2
        m_cyc = 4'b0100; m_stb = 4'b0100;
        step();
        s_err = 1'b1; #1;
        check("err_route", 32'(m_err), 32'(4'b0100));
        check("err_noack", 32'(m_ack), 32'(0));
        step();
        go_idle();

        // Slave never terminates
        m_cyc = 4'b0001; m_stb = 4'b0001;
        step();
        for (int i = 0; i < 12; i++) begin
            #1;
`ifdef WB_ARB_TIMEOUT_EN
            if (i == int'(TO) - 1) begin
                check("wd_err", 32'(m_err), 32'(4'b0001));
                check("wd_stb", 32'(s_stb), 32'(0));
            end else begin
                check("wd_noerr", 32'(m_err), 32'(0));
            end
`else
            check("stall_noerr", 32'(m_err), 32'(0));
            check("stall_stb",   32'(s_stb), 32'(1));
`endif
            step();
        end
        go_idle();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            for (int k = 0; k < int'(NM); k++) begin
                if (m_cyc[k]) m_cyc[k] = ($urandom_range(0, 3) != 0);
                else          m_cyc[k] = ($urandom_range(0, 2) == 0);
            end
            m_stb = NM'($urandom) & m_cyc;
            m_we  = NM'($urandom);
            m_adr = (NM*AW)'($urandom);
            m_dat = (NM*DW)'($urandom);
            s_dat = DW'($urandom);
            r = int'($urandom_range(0, 7));
            s_ack = (r < 4);
            s_err = (r == 4);
            step();
        end
        go_idle();

        // Asynchronous reset while master 1 is strobing
        m_cyc = 4'b0010; m_stb = 4'b0010;
        step();
        s_ack = 1'b1; #1;
        check("prerst_stb", 32'(s_stb), 32'(1));
        rst_n = 1'b0; #1;
        check("arst_gnt",  32'(gnt),   32'(0));
        check("arst_busy", 32'(busy),  32'(0));
        check("arst_cyc",  32'(s_cyc), 32'(0));
        check("arst_stb",  32'(s_stb), 32'(0));
        check("arst_ack",  32'(m_ack), 32'(0));
        own = -1; last = int'(NM) - 1; cnt = 0;
        m_cyc = 4'b1111; m_stb = 4'b0000; s_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", 32'(gnt), 32'(4'b0001));
        step();
        go_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised round-robin Wishbone arbiter that lets NUM_MASTERS Wishbone masters share one slave port, such as the IICMB register block. It is the next-generation RTL sibling of the Wishbone verification agent. It generalises the single-master agent topology to N requesters. It adds fair arbitration, per-tenure bus locking and an optional stall watchdog. It sits between the master-side fabric and a single Wishbone slave.

## Interface
- NUM_MASTERS, 4, number of requesting masters (2..16)
- ADDR_WIDTH, 2, Wishbone address width
- DATA_WIDTH, 8, Wishbone data width
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (only used with WB_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- m_err_o  out  NUM_MASTERS  per-master error
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side control
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i, s_err_i  in  1  slave termination
- gnt_o  out  NUM_MASTERS  one-hot current grant, registered
- busy_o  out  1  high while in OWNED

## Operation
- States: IDLE, OWNED.
- IDLE: if any m_cyc_i bit is high, grant the first requester found searching upward from (last+1) mod NUM_MASTERS, wrapping. Then go to OWNED. gnt_o is set on that edge, and `last` is updated to the granted index.
- OWNED: the granted master's cyc/stb/we/adr/dat drive the slave port. s_ack_i and s_err_i route only to the granted master's m_ack_o/m_err_o. All other masters see 0.
- Bus lock: the grant holds across multiple stb transfers for as long as the granted m_cyc_i stays high.
- Release: when the granted m_cyc_i is low in OWNED, return to IDLE and clear gnt_o.
- Requests from non-granted masters are ignored until release. Their signals never reach the slave.
- m_dat_o = s_dat_i at all times.
- Reset mid-transfer: outputs clear immediately. The slave sees cyc/stb drop with no handshake completion.

## Timing
- Reset values:
  - gnt_o = 0, busy_o = 0
  - s_cyc_o = s_stb_o = s_we_o = 0, s_adr_o = 0, s_dat_o = 0
  - m_ack_o = m_err_o = 0
  - `last` = NUM_MASTERS-1, so master 0 wins first.
- Grant latency: a request seen in cycle N drives s_cyc_o in cycle N+1.
- Ack/err/read-data paths are combinational. There is zero added latency per transfer.
- Slave outputs are 0 whenever state is IDLE.
- Release costs exactly one IDLE cycle with s_cyc_o low before the next grant, even when other requests are pending.
- The arbiter never registers or holds a termination. A slave ack arriving while the granted stb is low is dropped.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A counter increments each OWNED cycle with s_stb_o high and neither s_ack_i nor s_err_i.
  - It clears on any termination, on stb low, or on release.
  - On reaching TIMEOUT_CYCLES it pulses the granted m_err_o for one cycle, forces s_stb_o low that cycle, and clears.
  - The grant is kept; the master decides whether to release.
- WB_ARB_TIMEOUT_EN undefined: no counter exists, TIMEOUT_CYCLES is unused, and m_err_o reflects only s_err_i.

## Test plan
- Reset then single request: m_cyc_i=4'b0100, write adr=2 dat=8'hA5 -> gnt_o=4'b0100 one cycle later; slave sees adr 2, dat A5, we=1; s_ack_i returns on m_ack_o[2] only.
- Simultaneous requests: m_cyc_i=4'b1111 held, each master releases after one transfer -> grant order 0,1,2,3,0 with one idle cycle between tenures.
- Bus lock: master 1 performs 3 back-to-back reads while master 3 requests -> gnt_o stays 4'b0010 through all 3 acks; master 3 is granted 2 cycles after master 1 drops cyc.
- Error routing: granted master 2, s_err_i=1 -> m_err_o=4'b0100, m_ack_o=0.
- Async reset during OWNED with stb high -> all outputs 0 without a clock edge; the next grant after reset goes to master 0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> m_err_o pulses for the granted master on stall cycle 8 and s_stb_o is 0 that cycle. Without the macro, no error occurs and stb stays high.
